normalize_round_stage: RTL and testbench

//  Two-stage pipelined normalizer/rounder placed directly upstream of the FPU result

---
 rtl/normalize_round_stage.sv | 210 +++++++++++++++++++++
 tb/tb_normalize_round_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_round_stage.sv
// Two-stage normalizer/rounder: stage 1 normalizes the wide significand, stage 2 rounds to
// single precision and raises overflow/underflow/inexact. Valid/ready with a passthrough tag.
module normalize_round_stage #(
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [9:0]           in_exponent,
  input  logic [47:0]          in_fraction,
  input  logic [1:0]           in_round_mode,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 result_sign,
  output logic [9:0]           result_exponent,
  output logic [24:0]          result_fraction,
  output logic                 flag_overflow,
  output logic                 flag_underflow,
  output logic                 flag_inexact,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam logic [1:0] RmRne = 2'b00;
  localparam logic [1:0] RmRtz = 2'b01;
  localparam logic [1:0] RmRdn = 2'b10;
  localparam logic [1:0] RmRup = 2'b11;

  logic adv1, adv2;

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic signed [11:0]   s1_exp_q, s1_exp_d;
  logic [46:0]          s1_frac_q, s1_frac_d;
  logic                 s1_sticky_q, s1_sticky_d;
  logic                 s1_zero_q, s1_zero_d;
  logic [1:0]           s1_rm_q, s1_rm_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

  // Stage 2 state (drives the outputs directly)
  logic                 s2_valid_q, s2_valid_d;
  logic                 sign_q, sign_d;
  logic [9:0]           exp_q, exp_d;
  logic [24:0]          frac_q, frac_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 inx_q, inx_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  logic signed [11:0] exp_ext;
  logic [5:0]         lz;
  logic               lz_found;

  always_comb begin
    exp_ext  = {{2{in_exponent[9]}}, in_exponent};
    lz       = '0;
    lz_found = 1'b0;
    for (int i = 46; i >= 0; i--) begin
      if (!lz_found && in_fraction[i]) begin
        lz       = 6'(46 - i);
        lz_found = 1'b1;
      end
    end

    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_frac_d   = s1_frac_q;
    s1_sticky_d = s1_sticky_q;
    s1_zero_d   = s1_zero_q;
    s1_rm_d     = s1_rm_q;
    s1_tag_d    = s1_tag_q;
    if (adv1) begin
      s1_valid_d  = in_valid;
      s1_sign_d   = in_sign;
      s1_rm_d     = in_round_mode;
      s1_tag_d    = in_tag;
      s1_zero_d   = (in_fraction == '0);
      s1_sticky_d = 1'b0;
      if (in_fraction == '0) begin
        s1_exp_d  = '0;
        s1_frac_d = '0;
      end else if (in_fraction[47]) begin
        s1_exp_d    = exp_ext + 12'sd1;
        s1_frac_d   = in_fraction[47:1];
        s1_sticky_d = in_fraction[0];
      end else begin
        s1_exp_d  = exp_ext - $signed({6'b0, lz});
        s1_frac_d = in_fraction[46:0] << lz;
      end
    end
  end

  logic [23:0]        sig, sig_r;
  logic               g_bit, s_bit, inc, away;
  logic [24:0]        sum;
  logic signed [11:0] exp_r;

  always_comb begin
    sig   = s1_frac_q[46:23];
    g_bit = s1_frac_q[22];
    s_bit = (|s1_frac_q[21:0]) | s1_sticky_q;
    unique case (s1_rm_q)
      RmRne:   inc = g_bit & (s_bit | sig[0]);
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = s1_sign_q & (g_bit | s_bit);
      RmRup:   inc = ~s1_sign_q & (g_bit | s_bit);
      default: inc = 1'b0;
    endcase
    sum   = {1'b0, sig} + {24'b0, inc};
    sig_r = sum[24] ? 24'h800000 : sum[23:0];
    exp_r = sum[24] ? s1_exp_q + 12'sd1 : s1_exp_q;
    // Overflow rounds to infinity only when the mode pushes magnitude away from zero.
    away  = (s1_rm_q == RmRne) || (s1_rm_q == RmRdn && s1_sign_q) ||
            (s1_rm_q == RmRup && !s1_sign_q);

    s2_valid_d = s2_valid_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    frac_d     = frac_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inx_d      = inx_q;
    tag_d      = tag_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      sign_d     = s1_sign_q;
      tag_d      = s1_tag_q;
      exp_d      = '0;
      frac_d     = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      inx_d      = 1'b0;
      if (s1_zero_q) begin
        // signed zero, no exceptions
      end else if (exp_r >= 12'sd255) begin
        ovf_d = 1'b1;
        inx_d = 1'b1;
        if (away) begin
          exp_d = 10'd255;
        end else begin
          exp_d  = 10'd254;
          frac_d = 25'h0FFFFFF;
        end
      end else if (exp_r <= 12'sd0) begin
        unf_d = 1'b1;
        inx_d = 1'b1;
      end else begin
        exp_d  = exp_r[9:0];
        frac_d = {1'b0, sig_r};
        inx_d  = g_bit | s_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_sticky_q <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_rm_q     <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      tag_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_frac_q   <= s1_frac_d;
      s1_sticky_q <= s1_sticky_d;
      s1_zero_q   <= s1_zero_d;
      s1_rm_q     <= s1_rm_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid       = s2_valid_q;
  assign result_sign     = sign_q;
  assign result_exponent = exp_q;
  assign result_fraction = frac_q;
  assign flag_overflow   = ovf_q;
  assign flag_underflow  = unf_q;
  assign flag_inexact    = inx_q;
  assign out_tag         = tag_q;

endmodule

// File: tb/tb_normalize_round_stage.sv
// Bench for normalize_round_stage: arithmetic reference model with scoreboard, literal
// expectations pinning the model, plus stall and mid-flight reset scenarios.
module tb_normalize_round_stage;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sign;
  logic [9:0]    in_exponent;
  logic [47:0]   in_fraction;
  logic [1:0]    in_round_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, result_sign;
  logic [9:0]    result_exponent;
  logic [24:0]   result_fraction;
  logic          flag_overflow, flag_underflow, flag_inexact;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  normalize_round_stage #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_fraction(in_fraction),
    .in_round_mode(in_round_mode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result_sign(result_sign), .result_exponent(result_exponent),
    .result_fraction(result_fraction), .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow), .flag_inexact(flag_inexact), .out_tag(out_tag)
  );

  typedef struct packed {
    logic          sign;
    logic [9:0]    exp;
    logic [24:0]   frac;
    logic          ovf;
    logic          unf;
    logic          inx;
    logic [TW-1:0] tag;
  } res_t;

  res_t dut_res;
  assign dut_res = {result_sign, result_exponent, result_fraction, flag_overflow,
                    flag_underflow, flag_inexact, out_tag};

  res_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   out_cnt = 0;
  int   tag_n = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: locate the MSB, keep 24 bits below it, round from the discarded tail.
  function automatic res_t model(input logic s, input logic [9:0] e_in, input logic [47:0] f,
                                 input logic [1:0] rm, input logic [TW-1:0] tag);
    res_t        r;
    int          p, e;
    logic [63:0] ff, kept, mask;
    logic        g, st, inc, away;
    r = '0;
    r.sign = s;
    r.tag = tag;
    if (f == '0) return r;
    p = -1;
    for (int i = 0; i < 48; i++) if (f[i]) p = i;
    e = int'($signed(e_in)) + p - 46;
    ff = 64'(f);
    g = 1'b0;
    st = 1'b0;
    if (p >= 23) begin
      kept = ff >> (p - 23);
      if (p >= 24) begin
        g = ff[p-24];
        mask = (64'd1 << (p - 24)) - 64'd1;
        st = (ff & mask) != 0;
      end
    end else begin
      kept = ff << (23 - p);
    end
    case (rm)
      2'd0: inc = g & (st | kept[0]);
      2'd1: inc = 1'b0;
      2'd2: inc = s & (g | st);
      default: inc = !s & (g | st);
    endcase
    kept = kept + 64'(inc);
    if (kept == (64'd1 << 24)) begin
      kept = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) begin
      r.ovf = 1'b1;
      r.inx = 1'b1;
      away = (rm == 2'd0) || (rm == 2'd2 && s) || (rm == 2'd3 && !s);
      r.exp = away ? 10'd255 : 10'd254;
      r.frac = away ? 25'h0 : 25'h0FFFFFF;
    end else if (e <= 0) begin
      r.unf = 1'b1;
      r.inx = 1'b1;
    end else begin
      r.exp = e[9:0];
      r.frac = {1'b0, kept[23:0]};
      r.inx = g | st;
    end
    return r;
  endfunction

  function automatic res_t mk(input logic s, input logic [9:0] e, input logic [24:0] f,
                              input logic o, input logic u, input logic x);
    res_t r;
    r = '{sign: s, exp: e, frac: f, ovf: o, unf: u, inx: x, tag: '0};
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    res_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(dut_res), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("out%0d", out_cnt), 64'(dut_res), 64'(e));
          out_cnt++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, in_exponent, in_fraction, in_round_mode, in_tag));
    end
  end

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] f,
                       input logic [1:0] rm);
    in_valid = 1'b1;
    in_sign = s;
    in_exponent = e;
    in_fraction = f;
    in_round_mode = rm;
    in_tag = TW'(tag_n);
    tag_n++;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] f,
                      input logic [1:0] rm);
    drive(s, e, f, rm);
    wait_accept();
  endtask

  task automatic lit(input string name, input logic s, input logic [9:0] e,
                     input logic [47:0] f, input logic [1:0] rm, input res_t req);
    chk({"model_", name}, 64'(model(s, e, f, rm, '0)), 64'(req));
    send(s, e, f, rm);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [47:0] rnd_f;
  int          base_cnt;
  logic [7:0]  tag_a;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exponent = '0;
    in_fraction = '0;
    in_round_mode = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", 64'(dut_res), 64'd0);
    @(posedge clk);
    #1;

    lit("t1_norm", 0, 10'd127, 48'h4000_0000_0000, 2'd0, mk(0, 127, 25'h0800000, 0, 0, 0));
    lit("t2_bit47", 0, 10'd127, 48'hC000_0000_0000, 2'd0, mk(0, 128, 25'h0C00000, 0, 0, 0));
    lit("t3_tie_even", 0, 10'd127, 48'h4000_0040_0000, 2'd0, mk(0, 127, 25'h0800000, 0, 0, 1));
    lit("t3_tie_odd", 0, 10'd127, 48'h4000_00C0_0000, 2'd0, mk(0, 127, 25'h0800002, 0, 0, 1));
    lit("rne_above", 0, 10'd127, 48'h4000_0060_0000, 2'd0, mk(0, 127, 25'h0800001, 0, 0, 1));
    lit("t4_ovf_rne", 0, 10'd254, 48'h7FFF_FFFF_FFFF, 2'd0, mk(0, 255, 25'h0, 1, 0, 1));
    lit("t4_rtz", 0, 10'd254, 48'h7FFF_FFFF_FFFF, 2'd1, mk(0, 254, 25'h0FFFFFF, 0, 0, 1));
    lit("rup_neg", 1, 10'd254, 48'h7FFF_FFFF_FFFF, 2'd3, mk(1, 254, 25'h0FFFFFF, 0, 0, 1));
    lit("rdn_neg_ovf", 1, 10'd254, 48'h7FFF_FFFF_FFFF, 2'd2, mk(1, 255, 25'h0, 1, 0, 1));
    lit("rup_neg_ovf", 1, 10'd255, 48'h4000_0000_0000, 2'd3, mk(1, 254, 25'h0FFFFFF, 1, 0, 1));
    lit("t5_unf", 0, 10'd1, 48'h2000_0000_0000, 2'd0, mk(0, 0, 25'h0, 0, 1, 1));
    lit("t5_zero", 1, 10'd1, 48'h0, 2'd0, mk(1, 0, 25'h0, 0, 0, 0));
    lit("exp511", 0, 10'd511, 48'hC000_0000_0000, 2'd0, mk(0, 255, 25'h0, 1, 0, 1));
    lit("neg_exp", 1, 10'h3FB, 48'h4000_0000_0000, 2'd0, mk(1, 0, 25'h0, 0, 1, 1));
    lit("rtz_sticky", 0, 10'd100, 48'h4000_0000_0001, 2'd1, mk(0, 100, 25'h0800000, 0, 0, 1));
    lit("rup_sticky", 0, 10'd100, 48'h4000_0000_0001, 2'd3, mk(0, 100, 25'h0800001, 0, 0, 1));
    lit("deep_norm", 0, 10'd200, 48'h0000_0000_0001, 2'd0, mk(0, 154, 25'h0800000, 0, 0, 0));
    drain();

    // Random backpressure while streaming model-checked operands
    fork
      begin
        for (int k = 0; k < 14; k++) begin
          rnd_f = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 40);
          send(1'($urandom), 10'($urandom_range(0, 300)), rnd_f, 2'($urandom));
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Full stall: two ops held, the third refused until release
    @(posedge clk);
    #1 out_ready = 1'b0;
    base_cnt = out_cnt;
    tag_a = TW'(tag_n);
    send(0, 10'd130, 48'h5555_0000_0000, 2'd0);
    send(1, 10'd60, 48'h0123_4567_89AB, 2'd2);
    drive(0, 10'd90, 48'hFFFF_FFFF_FFFF, 2'd3);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_head_tag", 64'(out_tag), 64'(tag_a));
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    drain();
    chk("stall_count", 64'(out_cnt - base_cnt), 64'd3);

    // Reset with both stages full discards everything
    out_ready = 1'b0;
    send(0, 10'd127, 48'h4000_0000_0000, 2'd0);
    send(0, 10'd128, 48'h4000_0000_0000, 2'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit("post_reset", 0, 10'd127, 48'hC000_0000_0000, 2'd0, mk(0, 128, 25'h0C00000, 0, 0, 0));
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
